// File: rtl/bit_index_mask_builder_pkg.sv
// Shared definitions for the bit-index encoder/builder pair.
// An index equal to the vector width N is the "no bit / all-zeroes" sentinel.
package bit_index_mask_builder_pkg;

  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int sentinel_idx(input int n);
    return n;
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/bit_index_mask_builder_if.sv
// Index-beat input stream and assembled-frame output stream of the mask builder.
interface bit_index_mask_builder_if #(
  parameter int N = 8
);
  import bit_index_mask_builder_pkg::*;

  localparam int IW = idx_w(N);

  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_index;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [N-1:0]  m_mask;
  logic [IW-1:0] m_count;
  logic          m_dup;
  logic          m_oor;

  modport master (
    output s_valid, s_index, s_last, m_ready,
    input  s_ready, m_valid, m_mask, m_count, m_dup, m_oor
  );

  modport slave (
    input  s_valid, s_index, s_last, m_ready,
    output s_ready, m_valid, m_mask, m_count, m_dup, m_oor
  );

endinterface

// File: rtl/bit_index_mask_builder_index_onehot_decode.sv
// Index to one-hot decode; the sentinel and out-of-range indices decode to all zeroes.
module index_onehot_decode
  import bit_index_mask_builder_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [IW-1:0] index,
  output logic [N-1:0]  onehot,
  output logic          in_range
);

  logic [31:0] idx32;

  assign idx32    = 32'(index);
  assign in_range = (idx32 < N);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = (idx32 == i);
    end
  end

endmodule

// File: rtl/bit_index_mask_builder.sv
// Rebuilds an N-bit vector from a frame of bit-index beats and returns it with
// a population count and duplicate / out-of-range flags.
//
// state | meaning
// ACCUM | accepting beats, accumulator shows the running frame
// HOLD  | frame complete, outputs frozen until m_ready
module bit_index_mask_builder
  import bit_index_mask_builder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bit_index_mask_builder_if.slave  bus
);

  localparam int IW = idx_w(N);

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q;
  logic [IW-1:0] count_q;
  logic          dup_q, oor_q;
  logic          s_ready_c, m_valid_c;
  logic [N-1:0]  onehot;
  logic          in_range;
  logic          oor_beat;
  logic          accept;

  index_onehot_decode #(.N(N)) u_decode (
    .index    (bus.s_index),
    .onehot   (onehot),
    .in_range (in_range)
  );

  assign oor_beat = (32'(bus.s_index) > sentinel_idx(N));
  assign accept   = bus.s_valid && s_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // s_ready is gated by rst_n so it reads 0 for the whole reset pulse
  always_comb begin
    state_d   = state_q;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    case (state_q)
      ACCUM: begin
        s_ready_c = rst_n;
        if (bus.s_valid && rst_n && bus.s_last) state_d = HOLD;
      end
      HOLD: begin
        m_valid_c = 1'b1;
        if (bus.m_ready) state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else if (state_q == HOLD && bus.m_ready) begin
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else if (accept) begin
      if (in_range) begin
        // a repeated index never reaches the count, so it stays <= N
        if (|(onehot & mask_q)) begin
          dup_q <= 1'b1;
        end else begin
          mask_q  <= mask_q | onehot;
          count_q <= count_q + IW'(1);
        end
      end
      if (oor_beat) oor_q <= 1'b1;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;
  assign bus.m_mask  = mask_q;
  assign bus.m_count = count_q;
  assign bus.m_dup   = dup_q;
  assign bus.m_oor   = oor_q;

endmodule

// File: tb/tb_bit_index_mask_builder.sv
// Directed and random frames for bit_index_mask_builder (N=8), checked against a
// list-based reference model of the frame contents.
module tb_bit_index_mask_builder;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   beats[$];

  bit_index_mask_builder_if #(.N(8)) bus ();

  bit_index_mask_builder #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input int idx, input bit last);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_index = 4'(idx);
    bus.s_last  = last;
    while (!bus.s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("s_ready_wait", 32'(bus.s_ready), 32'd1);
    if (last) check("m_valid_early", 32'(bus.m_valid), 32'd0);
    @(posedge clk);
    beats.push_back(idx);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (last) check("m_valid_latency", 32'(bus.m_valid), 32'd1);
  endtask

  // Reference: the frame is a list of indices; the vector is the set of in-range ones.
  task automatic model(output logic [7:0] em, output int ec, output bit ed, output bit eo,
                       output int emax, output int emin);
    em = '0; ed = 1'b0; eo = 1'b0; emax = -1; emin = 99;
    foreach (beats[i]) begin
      int v;
      v = beats[i];
      if (v < 8) begin
        if (em[v]) ed = 1'b1;
        em[v] = 1'b1;
        if (v > emax) emax = v;
        if (v < emin) emin = v;
      end else if (v > 8) begin
        eo = 1'b1;
      end
    end
    ec = $countones(em);
  endtask

  task automatic encode(input logic [7:0] m, output int lead, output int trail, output bit az);
    lead = 8; trail = 8; az = (m == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        lead = i;
        if (trail == 8) trail = i;
      end
    end
  endtask

  task automatic finish_frame(input int stall);
    logic [7:0] em;
    int ec, emax, emin, lead, trail;
    bit ed, eo, az;
    model(em, ec, ed, eo, emax, emin);
    @(negedge clk);
    check("m_valid", 32'(bus.m_valid), 32'd1);
    check("s_ready_hold", 32'(bus.s_ready), 32'd0);
    check("m_mask", 32'(bus.m_mask), 32'(em));
    check("m_count", 32'(bus.m_count), 32'(ec));
    check("m_dup", 32'(bus.m_dup), 32'(ed));
    check("m_oor", 32'(bus.m_oor), 32'(eo));
    encode(bus.m_mask, lead, trail, az);
    if (emax < 0) begin
      check("enc_all_zeroes", 32'(az), 32'd1);
      check("enc_lead_sentinel", 32'(lead), 32'd8);
    end else begin
      check("enc_lead", 32'(lead), 32'(emax));
      check("enc_trail", 32'(trail), 32'(emin));
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_m_valid", 32'(bus.m_valid), 32'd1);
      check("stall_s_ready", 32'(bus.s_ready), 32'd0);
      check("stall_m_mask", 32'(bus.m_mask), 32'(em));
      check("stall_m_count", 32'(bus.m_count), 32'(ec));
      check("stall_m_dup", 32'(bus.m_dup), 32'(ed));
    end
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    check("post_hs_m_valid", 32'(bus.m_valid), 32'd0);
    check("post_hs_s_ready", 32'(bus.s_ready), 32'd1);
    check("post_hs_clear", 32'({bus.m_mask, bus.m_count, bus.m_dup, bus.m_oor}), 32'd0);
    beats.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_index = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_outputs", 32'({bus.m_mask, bus.m_count, bus.m_dup, bus.m_oor}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 32'(bus.s_ready), 32'd1);

    // Basic frame
    send_beat(0, 0); send_beat(3, 0); send_beat(7, 1);
    finish_frame(0);

    // Duplicate
    send_beat(5, 0); send_beat(5, 0); send_beat(2, 1);
    finish_frame(1);

    // Empty frame, then out-of-range
    send_beat(8, 1);
    finish_frame(0);
    send_beat(9, 0); send_beat(1, 1);
    finish_frame(0);

    // Full frame with downstream stalled and a beat pending
    for (int i = 0; i < 8; i++) send_beat(i, i == 7);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_index = 4'd0;
    bus.s_last  = 1'b1;
    finish_frame(5);

    // Reset mid-frame discards the partial frame
    send_beat(1, 0); send_beat(4, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    check("midrst_mask", 32'(bus.m_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beats.delete();
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    send_beat(6, 1);
    finish_frame(0);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) send_beat($urandom_range(0, 11), b == len - 1);
      finish_frame($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
